// File: rtl/eeg_filter_pkg.sv
// Shared types and arithmetic helpers for the EEG adaptive noise-cancelling filter.
package eeg_filter_pkg;

  localparam int Q_FRAC   = 15;
  localparam int SAMPLE_W = 16;
  localparam int SAT_IN_W = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_MAC,
    ST_ERR,
    ST_UPD,
    ST_OUT
  } state_e;

  // Callers sign-extend into SAT_IN_W so one clamp serves every datapath width.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] v);
    if (v > 48'sd32767)       return 16'sh7fff;
    else if (v < -48'sd32768) return 16'sh8000;
    else                      return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/eeg_sat_mac.sv
// Single shared signed 16x16 multiplier: accumulate mode for the filter MAC,
// shifted saturating-add mode for the weight update.
module eeg_sat_mac
  import eeg_filter_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic                     mode_upd,
  input  logic signed [15:0]       a,
  input  logic signed [15:0]       b,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic signed [15:0]       w_in,
  input  logic [3:0]               shift,
  output logic signed [ACC_W-1:0] acc_out,
  output logic signed [15:0]       w_out
);

  logic signed [31:0]         prod;
  logic signed [31:0]         prod_shr;
  logic [4:0]                 shift_amt;
  logic signed [SAT_IN_W-1:0] upd_sum;

  always_comb begin
    prod      = 32'(a) * 32'(b);
    shift_amt = 5'(Q_FRAC) + {1'b0, shift};
    prod_shr  = prod >>> shift_amt;
    upd_sum   = SAT_IN_W'(w_in) + SAT_IN_W'(prod_shr);
    acc_out   = acc_in;
    w_out     = w_in;
    if (mode_upd) w_out   = sat16(upd_sum);
    else          acc_out = acc_in + ACC_W'(prod);
  end

endmodule

// File: rtl/eeg_apa_sequencer.sv
// Time-multiplexed adaptive filter sequencer: MAC, error and LMS weight update
// phases share one multiplier; samples in and results out via valid/ready.
//
//   state | meaning
//   IDLE  | waiting for a sample pair or a weight clear
//   CLR   | zero all weights (one cycle)
//   MAC   | y accumulation, one tap per cycle
//   ERR   | saturate y, compute e
//   UPD   | weight update, one tap per cycle
//   OUT   | result presented until out_ready
module eeg_apa_sequencer
  import eeg_filter_pkg::*;
#(
  parameter int M       = 16,
  parameter int MON_TAP = 15,
  parameter int ACC_W   = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] noisy_signal,
  input  logic [15:0] desired_signal,
  input  logic        adapt_en,
  input  logic [3:0]  mu_shift,
  input  logic        clear_weights,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] filtered_signal,
  output logic [15:0] error_signal,
  output logic [15:0] weight_mon,
  output logic        busy
);

  localparam int KW = (M > 1) ? $clog2(M) : 1;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [15:0]       x_q [M];
  logic signed [15:0]       x_d [M];
  logic signed [15:0]       w_q [M];
  logic signed [15:0]       w_d [M];
  logic signed [15:0]       d_q, d_d;
  logic                     adapt_q, adapt_d;
  logic [3:0]               mu_q, mu_d;
  logic signed [15:0]       y_q, y_d;
  logic signed [15:0]       e_q, e_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [15:0]       weight_mon_q, weight_mon_d;

  logic                     mac_upd;
  logic signed [15:0]       mac_a;
  logic signed [ACC_W-1:0]  mac_acc;
  logic signed [15:0]       mac_w;
  logic signed [15:0]       y_c;
  logic signed [15:0]       e_c;
  logic signed [16:0]       diff_c;
  logic                     k_last;

  assign mac_upd = (state_q == ST_UPD);
  assign mac_a   = mac_upd ? e_q : w_q[k_q];
  assign k_last  = (k_q == KW'(M - 1));

  eeg_sat_mac #(.ACC_W(ACC_W)) u_mac (
    .mode_upd (mac_upd),
    .a        (mac_a),
    .b        (x_q[k_q]),
    .acc_in   (acc_q),
    .w_in     (w_q[k_q]),
    .shift    (mu_q),
    .acc_out  (mac_acc),
    .w_out    (mac_w)
  );

  always_comb begin
    y_c    = sat16(SAT_IN_W'(acc_q >>> Q_FRAC));
    diff_c = 17'(d_q) - 17'(y_c);
    e_c    = sat16(SAT_IN_W'(diff_c));
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    x_d          = x_q;
    w_d          = w_q;
    d_d          = d_q;
    adapt_d      = adapt_q;
    mu_d         = mu_q;
    y_d          = y_q;
    e_d          = e_q;
    out_valid_d  = out_valid_q;
    weight_mon_d = weight_mon_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_weights) begin
          state_d = ST_CLR;
        end else if (in_valid) begin
          x_d[0] = noisy_signal;
          for (int i = 1; i < M; i++) x_d[i] = x_q[i-1];
          d_d     = desired_signal;
          adapt_d = adapt_en;
          mu_d    = mu_shift;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_CLR: begin
        for (int i = 0; i < M; i++) w_d[i] = '0;
        state_d = ST_IDLE;
      end
      ST_MAC: begin
        acc_d = mac_acc;
        if (k_last) begin
          k_d     = '0;
          state_d = ST_ERR;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_ERR: begin
        y_d = y_c;
        e_d = e_c;
        k_d = '0;
        if (adapt_q) begin
          state_d = ST_UPD;
        end else begin
          out_valid_d  = 1'b1;
          weight_mon_d = w_q[MON_TAP];
          state_d      = ST_OUT;
        end
      end
      ST_UPD: begin
        w_d[k_q] = mac_w;
        if (k_last) begin
          // The last tap is written on this same edge, so bypass it into the monitor.
          out_valid_d  = 1'b1;
          weight_mon_d = (k_q == KW'(MON_TAP)) ? mac_w : w_q[MON_TAP];
          k_d          = '0;
          state_d      = ST_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      acc_q        <= '0;
      for (int i = 0; i < M; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      d_q          <= '0;
      adapt_q      <= 1'b0;
      mu_q         <= '0;
      y_q          <= '0;
      e_q          <= '0;
      out_valid_q  <= 1'b0;
      weight_mon_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      w_q          <= w_d;
      d_q          <= d_d;
      adapt_q      <= adapt_d;
      mu_q         <= mu_d;
      y_q          <= y_d;
      e_q          <= e_d;
      out_valid_q  <= out_valid_d;
      weight_mon_q <= weight_mon_d;
    end
  end

  assign in_ready        = (state_q == ST_IDLE) && !clear_weights;
  assign busy            = (state_q != ST_IDLE);
  assign out_valid       = out_valid_q;
  assign filtered_signal = y_q;
  assign error_signal    = e_q;
  assign weight_mon      = weight_mon_q;

endmodule

// File: tb/tb_eeg_apa_sequencer.sv
// Directed bench for eeg_apa_sequencer with M=4, monitor on tap 0.
module tb_eeg_apa_sequencer;
  import eeg_filter_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] noisy_signal;
  logic signed [15:0] desired_signal;
  logic               adapt_en;
  logic [3:0]         mu_shift;
  logic               clear_weights;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] filtered_signal;
  logic signed [15:0] error_signal;
  logic signed [15:0] weight_mon;
  logic               busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  eeg_apa_sequencer #(.M(4), .MON_TAP(0), .ACC_W(40)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .noisy_signal    (noisy_signal),
    .desired_signal  (desired_signal),
    .adapt_en        (adapt_en),
    .mu_shift        (mu_shift),
    .clear_weights   (clear_weights),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .filtered_signal (filtered_signal),
    .error_signal    (error_signal),
    .weight_mon      (weight_mon),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Present one sample once in_ready, then count edges until out_valid.
  task automatic send_frame(input logic signed [15:0] x, input logic signed [15:0] d,
                            input logic adapt, input logic [3:0] mu, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    noisy_signal   = x;
    desired_signal = d;
    adapt_en       = adapt;
    mu_shift       = mu;
    in_valid       = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (filtered_signal !== 16'sd0) $display("FAIL reset_y got %0d exp 0", filtered_signal); else pass_cnt++;
    total_cnt++; if (error_signal !== 16'sd0) $display("FAIL reset_e got %0d exp 0", error_signal); else pass_cnt++;
    total_cnt++; if (weight_mon !== 16'sd0) $display("FAIL reset_wmon got %0d exp 0", weight_mon); else pass_cnt++;
  endtask

  task automatic test_first_update();
    int lat;
    send_frame(16'sd16384, 16'sd8192, 1'b1, 4'd1, lat);
    total_cnt++; if (lat != 9) $display("FAIL first_latency got %0d exp 9", lat); else pass_cnt++;
    total_cnt++; if (filtered_signal !== 16'sd0) $display("FAIL first_y got %0d exp 0", filtered_signal); else pass_cnt++;
    total_cnt++; if (error_signal !== 16'sd8192) $display("FAIL first_e got %0d exp 8192", error_signal); else pass_cnt++;
    total_cnt++; if (weight_mon !== 16'sd2048) $display("FAIL first_wmon got %0d exp 2048", weight_mon); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      total_cnt++; if (dut.w_q[i] !== 16'sd0) $display("FAIL first_w%0d got %0d exp 0", i, dut.w_q[i]); else pass_cnt++;
    end
    release_out();
  endtask

  task automatic test_saturation();
    int lat;
    send_frame(16'sd32767, 16'sh8000, 1'b1, 4'd1, lat);
    total_cnt++; if (lat != 9) $display("FAIL sat_latency got %0d exp 9", lat); else pass_cnt++;
    total_cnt++; if (filtered_signal !== 16'sd2047) $display("FAIL sat_y got %0d exp 2047", filtered_signal); else pass_cnt++;
    total_cnt++; if (error_signal !== 16'sh8000) $display("FAIL sat_e got %0d exp -32768", error_signal); else pass_cnt++;
    total_cnt++; if (weight_mon !== -16'sd14336) $display("FAIL sat_wmon got %0d exp -14336", weight_mon); else pass_cnt++;
    total_cnt++; if (dut.w_q[0] !== -16'sd14336) $display("FAIL sat_w0 got %0d exp -14336", dut.w_q[0]); else pass_cnt++;
    total_cnt++; if (dut.w_q[1] !== -16'sd8192) $display("FAIL sat_w1 got %0d exp -8192", dut.w_q[1]); else pass_cnt++;
    total_cnt++; if (dut.w_q[2] !== 16'sd0) $display("FAIL sat_w2 got %0d exp 0", dut.w_q[2]); else pass_cnt++;
    total_cnt++; if (dut.w_q[3] !== 16'sd0) $display("FAIL sat_w3 got %0d exp 0", dut.w_q[3]); else pass_cnt++;
    release_out();
  endtask

  // Leaves the DUT in OUT for the hold test. x = {8192, 32767, 16384, 0}, w = {-14336, -8192, 0, 0}.
  task automatic test_no_adapt();
    int lat;
    send_frame(16'sd8192, 16'sd0, 1'b0, 4'd1, lat);
    total_cnt++; if (lat != 5) $display("FAIL noadapt_latency got %0d exp 5", lat); else pass_cnt++;
    total_cnt++; if (filtered_signal !== -16'sd11776) $display("FAIL noadapt_y got %0d exp -11776", filtered_signal); else pass_cnt++;
    total_cnt++; if (error_signal !== 16'sd11776) $display("FAIL noadapt_e got %0d exp 11776", error_signal); else pass_cnt++;
    total_cnt++; if (dut.w_q[0] !== -16'sd14336) $display("FAIL noadapt_w0 got %0d exp -14336", dut.w_q[0]); else pass_cnt++;
    total_cnt++; if (dut.w_q[1] !== -16'sd8192) $display("FAIL noadapt_w1 got %0d exp -8192", dut.w_q[1]); else pass_cnt++;
    total_cnt++; if (weight_mon !== -16'sd14336) $display("FAIL noadapt_wmon got %0d exp -14336", weight_mon); else pass_cnt++;
  endtask

  task automatic test_hold_and_release();
    in_valid     = 1'b1;
    noisy_signal = 16'sd1234;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_valid c%0d got %b exp 1", c, out_valid); else pass_cnt++;
      total_cnt++; if (filtered_signal !== -16'sd11776) $display("FAIL hold_y c%0d got %0d exp -11776", c, filtered_signal); else pass_cnt++;
      total_cnt++; if (error_signal !== 16'sd11776) $display("FAIL hold_e c%0d got %0d exp 11776", c, error_signal); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready c%0d got %b exp 0", c, in_ready); else pass_cnt++;
    end
    total_cnt++; if (dut.x_q[0] !== 16'sd8192) $display("FAIL hold_x0 got %0d exp 8192", dut.x_q[0]); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL release_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL release_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_clear_priority();
    int lat;
    clear_weights  = 1'b1;
    in_valid       = 1'b1;
    noisy_signal   = 16'sd4096;
    desired_signal = 16'sd0;
    adapt_en       = 1'b0;
    mu_shift       = 4'd1;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL clr_in_ready got %b exp 0", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    clear_weights = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL clr_busy got %b exp 1", busy); else pass_cnt++;
    total_cnt++; if (dut.x_q[0] !== 16'sd8192) $display("FAIL clr_x0 got %0d exp 8192", dut.x_q[0]); else pass_cnt++;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (dut.w_q[i] !== 16'sd0) $display("FAIL clr_w%0d got %0d exp 0", i, dut.w_q[i]); else pass_cnt++;
    end
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL clr_after_in_ready got %b exp 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (dut.x_q[0] !== 16'sd4096) $display("FAIL clr_accept_x0 got %0d exp 4096", dut.x_q[0]); else pass_cnt++;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (lat != 5) $display("FAIL clr_latency got %0d exp 5", lat); else pass_cnt++;
    total_cnt++; if (filtered_signal !== 16'sd0) $display("FAIL clr_y got %0d exp 0", filtered_signal); else pass_cnt++;
    total_cnt++; if (error_signal !== 16'sd0) $display("FAIL clr_e got %0d exp 0", error_signal); else pass_cnt++;
    total_cnt++; if (weight_mon !== 16'sd0) $display("FAIL clr_wmon got %0d exp 0", weight_mon); else pass_cnt++;
    release_out();
  endtask

  task automatic test_reset_mid_update();
    noisy_signal   = 16'sd1000;
    desired_signal = 16'sd5000;
    adapt_en       = 1'b1;
    mu_shift       = 4'd0;
    in_valid       = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total_cnt++; if (dut.state_q !== ST_UPD) $display("FAIL mid_state got %0d exp %0d", dut.state_q, ST_UPD); else pass_cnt++;
    total_cnt++; if (dut.k_q !== 2'd2) $display("FAIL mid_k got %0d exp 2", dut.k_q); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b exp 1", in_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (dut.w_q[i] !== 16'sd0) $display("FAIL mid_w%0d got %0d exp 0", i, dut.w_q[i]); else pass_cnt++;
      total_cnt++; if (dut.x_q[i] !== 16'sd0) $display("FAIL mid_x%0d got %0d exp 0", i, dut.x_q[i]); else pass_cnt++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    noisy_signal   = '0;
    desired_signal = '0;
    adapt_en       = 1'b0;
    mu_shift       = '0;
    clear_weights  = 1'b0;
    out_ready      = 1'b0;
    test_reset();
    test_first_update();
    test_saturation();
    test_no_adapt();
    test_hold_and_release();
    test_clear_priority();
    test_reset_mid_update();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
